usb_tx_packetizer: RTL and testbench

USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

---
 rtl/usb_tx_pkg.sv | 40 ++++
 rtl/usb_crc16.sv | 36 +++
 rtl/usb_tx_packetizer.sv | 188 ++++++++++++++++++
 tb/tb_usb_tx_packetizer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared codes, PIDs, CRC constants and FSM states for the USB TX packetizer
package usb_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4,
        TX_STALL = 3'd5
    } tx_packet_e;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    // 0x8005 bit-reversed, for an LSB-first shift register
    localparam logic [15:0] CRC16_POLY      = 16'h8005;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J, DONE
    } state_e;

    function automatic logic [7:0] pid_byte(input logic [2:0] code);
        case (code)
            TX_DATA0: return PID_DATA0;
            TX_DATA1: return PID_DATA1;
            TX_ACK:   return PID_ACK;
            TX_NAK:   return PID_NAK;
            TX_STALL: return PID_STALL;
            default:  return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - serial reflected CRC16 with bit enable and clear
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC16_INIT;
        end else if (en_i) begin
            crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ bit_i) ? CRC16_POLY_REFL : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    // Exposes the value including the bit absorbed this cycle so the CRC field can load on the same edge
    assign crc_o = crc_d;

endmodule

// File: rtl/usb_tx_packetizer.sv
// rtl/usb_tx_packetizer.sv - USB low-level TX: SYNC/PID/data/CRC framing, bit stuffing, NRZI, EOP
module usb_tx_packetizer
    import usb_tx_pkg::*;
#(
    parameter int CLK_DIV   = 8,
    parameter int OCC_W     = 7,
    parameter int MAX_BYTES = 64,
    parameter bit STUFF_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic [2:0]       TX_packet,
    input  logic [7:0]       TX_packet_data,
    output logic             get_TX_packet_data,
    output logic             TX_transfer_active,
    output logic             packet_done,
    output logic             TX_error,
    output logic             dp_out,
    output logic             dm_out
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [2:0]       ones_q;
    logic             stuff_q;
    logic [CNT_W-1:0] bytes_q;
    logic [2:0]       code_q;
    logic             is_data_q;
    logic             dp_q, dm_q, get_q, err_q;

    logic [15:0]      crc;
    logic [CNT_W-1:0] occ_cap;
    logic             bit_end, stuff_due, load_data, tx_bit;
    state_e           nxt_state;
    logic [7:0]       nxt_byte;

    assign occ_cap   = (32'(buffer_occupancy) > 32'(MAX_BYTES)) ? CNT_W'(MAX_BYTES)
                                                                : CNT_W'(buffer_occupancy);
    assign bit_end   = (div_q == DIV_W'(CLK_DIV - 1));
    assign stuff_due = STUFF_EN && !stuff_q && shift_q[0] && (ones_q == 3'd5);
    assign load_data = !stuff_due && (bit_cnt_q == 3'd7) && (nxt_state == DATA);

    // Field that follows the current byte, and the first bit it puts on the wire
    always_comb begin
        nxt_state = state_q;
        nxt_byte  = shift_q;
        case (state_q)
            SYNC: begin
                nxt_state = PID;
                nxt_byte  = pid_byte(code_q);
            end
            PID, DATA: begin
                if (!is_data_q) begin
                    nxt_state = EOP_SE0;
                end else if (bytes_q != '0) begin
                    nxt_state = DATA;
                    nxt_byte  = TX_packet_data;
                end else begin
                    nxt_state = CRC_LO;
                    nxt_byte  = ~crc[7:0];
                end
            end
            CRC_LO: begin
                nxt_state = CRC_HI;
                nxt_byte  = ~crc[15:8];
            end
            CRC_HI:  nxt_state = EOP_SE0;
            default: ;
        endcase
        if (stuff_due) begin
            tx_bit = 1'b0;
        end else if (bit_cnt_q != 3'd7) begin
            tx_bit = shift_q[1];
        end else begin
            tx_bit = nxt_byte[0];
        end
    end

    usb_crc16 u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .clr_i (state_q == IDLE),
        .en_i  (bit_end && (state_q == DATA) && !stuff_q),
        .bit_i (shift_q[0]),
        .crc_o (crc)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ones_q    <= '0;
            stuff_q   <= 1'b0;
            bytes_q   <= '0;
            code_q    <= '0;
            is_data_q <= 1'b0;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
            get_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            get_q <= 1'b0;
            err_q <= 1'b0;
            div_q <= (state_q == IDLE || bit_end) ? '0 : div_q + DIV_W'(1);
            case (state_q)
                IDLE: begin
                    dp_q <= 1'b1;
                    dm_q <= 1'b0;
                    if (TX_packet inside {[3'd1:3'd5]}) begin
                        state_q   <= SYNC;
                        code_q    <= TX_packet;
                        is_data_q <= (TX_packet == TX_DATA0) || (TX_packet == TX_DATA1);
                        bytes_q   <= occ_cap;
                        bit_cnt_q <= '0;
                        shift_q   <= SYNC_BYTE;
                        ones_q    <= '0;
                        stuff_q   <= 1'b0;
                        // SYNC opens with a 0, so the line leaves J for K immediately
                        dp_q      <= 1'b0;
                        dm_q      <= 1'b1;
                    end else if (TX_packet[2:1] == 2'b11) begin
                        err_q <= 1'b1;
                    end
                end
                SYNC, PID, DATA, CRC_LO, CRC_HI: begin
                    if (div_q == DIV_W'(CLK_DIV - 2)) get_q <= load_data;
                    if (bit_end) begin
                        if (stuff_due) begin
                            stuff_q <= 1'b1;
                            ones_q  <= '0;
                        end else begin
                            // A stuffed bit defers the byte advance until it has been sent
                            stuff_q <= 1'b0;
                            ones_q  <= (!stuff_q && shift_q[0]) ? ones_q + 3'd1 : 3'd0;
                            if (bit_cnt_q != 3'd7) begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                shift_q   <= {1'b0, shift_q[7:1]};
                            end else begin
                                bit_cnt_q <= '0;
                                state_q   <= nxt_state;
                                shift_q   <= nxt_byte;
                                if (nxt_state == DATA) bytes_q <= bytes_q - CNT_W'(1);
                            end
                        end
                        if (!stuff_due && bit_cnt_q == 3'd7 && nxt_state == EOP_SE0) begin
                            dp_q <= 1'b0;
                            dm_q <= 1'b0;
                        end else if (!tx_bit) begin
                            dp_q <= ~dp_q;
                            dm_q <= ~dm_q;
                        end
                    end
                end
                EOP_SE0: begin
                    if (bit_end) begin
                        if (bit_cnt_q == 3'd1) begin
                            state_q   <= EOP_J;
                            bit_cnt_q <= '0;
                            dp_q      <= 1'b1;
                            dm_q      <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                EOP_J:   if (bit_end) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign get_TX_packet_data = get_q;
    assign TX_transfer_active = (state_q != IDLE);
    assign packet_done        = (state_q == DONE);
    assign TX_error           = err_q;
    assign dp_out             = dp_q;
    assign dm_out             = dm_q;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// tb/tb_usb_tx_packetizer.sv - directed and randomized bench for usb_tx_packetizer against a bit-stream model
module tb_usb_tx_packetizer;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [6:0] buffer_occupancy;
    logic [2:0] TX_packet;
    logic [7:0] TX_packet_data;
    logic       get_TX_packet_data, TX_transfer_active, packet_done, TX_error, dp_out, dm_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] data_arr [128];
    int         data_idx;
    bit         get_prev, cap;
    logic [1:0] w_q[$];
    bit         g_q[$], a_q[$], d_q[$], e_q[$];

    usb_tx_packetizer #(.CLK_DIV(D), .OCC_W(7), .MAX_BYTES(64), .STUFF_EN(1'b1)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .buffer_occupancy   (buffer_occupancy),
        .TX_packet          (TX_packet),
        .TX_packet_data     (TX_packet_data),
        .get_TX_packet_data (get_TX_packet_data),
        .TX_transfer_active (TX_transfer_active),
        .packet_done        (packet_done),
        .TX_error           (TX_error),
        .dp_out             (dp_out),
        .dm_out             (dm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: supplies the FIFO byte stream and records outputs mid-cycle
    task automatic tick();
        @(negedge clk);
        if (get_prev) data_idx++;
        get_prev       = get_TX_packet_data;
        TX_packet_data = data_arr[data_idx % 128];
        if (cap) begin
            w_q.push_back({dp_out, dm_out});
            g_q.push_back(get_TX_packet_data);
            a_q.push_back(TX_transfer_active);
            d_q.push_back(packet_done);
            e_q.push_back(TX_error);
        end
    endtask

    function automatic logic [7:0] pid_of(input logic [2:0] c);
        case (c)
            3'd1:    return 8'hC3;
            3'd2:    return 8'h4B;
            3'd3:    return 8'hD2;
            3'd4:    return 8'h5A;
            default: return 8'h1E;
        endcase
    endfunction

    function automatic logic [15:0] crc_ref(input int n);
        logic [15:0] c;
        logic [7:0]  by;
        c = 16'hFFFF;
        for (int j = 0; j < n; j++) begin
            by = data_arr[j];
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ by[b]) c = (c >> 1) ^ 16'hA001;
                else              c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [1:0] sym(input int k);
        return w_q[k * D + D / 2];
    endfunction

    task automatic run_packet(input logic [2:0] code, input int occ, input bit fixed,
                              input logic [7:0] fval, input string tag);
        int         nb, n, ones, bad, gbad, acnt, dcnt, ecnt;
        logic [15:0] crc;
        logic [7:0] fl[$];
        logic [7:0] cur;
        bit         sb[$];
        int         exp_get[$], act_get[$];
        logic [1:0] ew[$];
        logic       lvl;
        for (int i = 0; i < 128; i++) data_arr[i] = fixed ? fval : 8'($urandom);
        data_idx = 0; get_prev = 0; TX_packet_data = data_arr[0];
        w_q.delete(); g_q.delete(); a_q.delete(); d_q.delete(); e_q.delete();
        TX_packet = code; buffer_occupancy = 7'(occ);
        cap = 1;
        tick();
        TX_packet = 3'($urandom_range(0, 7));
        buffer_occupancy = 7'($urandom);
        n = 0;
        while (d_q[d_q.size() - 1] == 1'b0 && n < 9000) begin
            tick();
            n++;
        end
        TX_packet = 3'd0;
        cap = 0;
        chk({tag, "_done_seen"}, 32'(d_q[d_q.size() - 1]), 1);

        nb = (code == 3'd1 || code == 3'd2) ? ((occ > 64) ? 64 : occ) : 0;
        fl.push_back(8'h80);
        fl.push_back(pid_of(code));
        for (int j = 0; j < nb; j++) fl.push_back(data_arr[j]);
        if (code == 3'd1 || code == 3'd2) begin
            crc = crc_ref(nb);
            fl.push_back(~crc[7:0]);
            fl.push_back(~crc[15:8]);
        end
        ones = 0;
        for (int i = 0; i < fl.size(); i++) begin
            cur = fl[i];
            for (int b = 0; b < 8; b++) begin
                if (i >= 2 && i < 2 + nb && b == 0) exp_get.push_back(sb.size() * D - 1);
                sb.push_back(cur[b]);
                ones = cur[b] ? ones + 1 : 0;
                if (ones == 6) begin
                    sb.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        lvl = 1'b1;
        foreach (sb[i]) begin
            if (!sb[i]) lvl = ~lvl;
            repeat (D) ew.push_back(lvl ? 2'b10 : 2'b01);
        end
        repeat (2 * D) ew.push_back(2'b00);
        repeat (D + 1) ew.push_back(2'b10);

        chk({tag, "_length"}, w_q.size(), ew.size());
        bad = 0;
        for (int i = 0; i < w_q.size() && i < ew.size(); i++) if (w_q[i] !== ew[i]) bad++;
        chk({tag, "_wire_mismatches"}, bad, 0);
        foreach (g_q[i]) if (g_q[i]) act_get.push_back(i);
        chk({tag, "_get_count"}, act_get.size(), exp_get.size());
        gbad = 0;
        for (int i = 0; i < act_get.size() && i < exp_get.size(); i++) if (act_get[i] != exp_get[i]) gbad++;
        chk({tag, "_get_timing"}, gbad, 0);
        acnt = 0; dcnt = 0; ecnt = 0;
        foreach (a_q[i]) begin
            if (!a_q[i]) acnt++;
            if (d_q[i])  dcnt++;
            if (e_q[i])  ecnt++;
        end
        chk({tag, "_active_gaps"}, acnt, 0);
        chk({tag, "_done_pulses"}, dcnt, 1);
        chk({tag, "_error_pulses"}, ecnt, 0);
        tick();
        chk({tag, "_idle_after"}, {TX_transfer_active, dp_out, dm_out}, 3'b010);
    endtask

    initial begin
        int         cnt, se0;
        logic [7:0] sv;
        logic [8:0] dec;
        for (int i = 0; i < 128; i++) data_arr[i] = 8'h00;
        n_rst = 1'b0; TX_packet = 3'd0; buffer_occupancy = 7'd0; TX_packet_data = 8'h00;
        cap = 0; get_prev = 0; data_idx = 0;
        repeat (3) tick();
        chk("reset_state", {dp_out, dm_out, TX_transfer_active, get_TX_packet_data, packet_done, TX_error}, 6'b100000);
        n_rst = 1'b1;
        tick();

        run_packet(3'd3, $urandom_range(0, 127), 0, 8'h00, "ack");
        chk("ack_cycles", w_q.size(), 153);
        for (int k = 0; k < 8; k++) sv[k] = w_q[k * D + 4][1];
        chk("ack_sync_kjkjkjkk", sv, 8'b00101010);
        cnt = 0;
        foreach (g_q[i]) if (g_q[i]) cnt++;
        chk("ack_no_get", cnt, 0);

        run_packet(3'd1, 0, 0, 8'h00, "zlp");
        cnt = 0;
        for (int k = 16; k < 32; k++) if (sym(k) !== sym(k - 1)) cnt++;
        chk("zlp_crc_toggles", cnt, 16);
        chk("zlp_eop", {sym(32), sym(33), sym(34)}, 6'b000010);

        run_packet(3'd2, 1, 1, 8'hFF, "ff_stuff");
        for (int i = 0; i < 9; i++) dec[i] = (sym(16 + i) === sym(15 + i));
        chk("ff_stuff_bits", dec, 9'h1BF);

        run_packet(3'd1, 100, 0, 8'h00, "cap64");
        cnt = 0;
        foreach (g_q[i]) if (g_q[i]) cnt++;
        chk("cap64_gets", cnt, 64);

        for (int r = 0; r < 6; r++)
            run_packet(3'($urandom_range(1, 5)), $urandom_range(0, 12), 0, 8'h00, $sformatf("rand%0d", r));
        run_packet(3'd2, 3, 1, 8'hFF, "ff3");

        TX_packet = 3'd7;
        tick();
        chk("err7_pulse", {TX_error, TX_transfer_active, dp_out, dm_out, get_TX_packet_data}, 5'b10100);
        TX_packet = 3'd6;
        tick();
        chk("err6_pulse", {TX_error, TX_transfer_active, dp_out, dm_out}, 4'b1010);
        TX_packet = 3'd0;
        tick();
        chk("err_clear", {TX_error, TX_transfer_active}, 2'b00);

        for (int i = 0; i < 128; i++) data_arr[i] = 8'($urandom);
        data_idx = 0; get_prev = 0;
        TX_packet = 3'd1; buffer_occupancy = 7'd5;
        tick();
        TX_packet = 3'd0;
        repeat (199) tick();
        chk("abort_was_active", TX_transfer_active, 1'b1);
        n_rst = 1'b0;
        tick();
        chk("abort_state", {dp_out, dm_out, TX_transfer_active, get_TX_packet_data, packet_done, TX_error}, 6'b100000);
        se0 = 0;
        repeat (20) begin
            tick();
            if ({dp_out, dm_out} !== 2'b10) se0++;
        end
        chk("abort_no_eop", se0, 0);
        n_rst = 1'b1;
        tick();
        run_packet(3'd3, 7, 0, 8'h00, "ack_after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
